// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with count, programmable level flags, sticky errors, FWFT option
// Pointers carry an extra wrap bit so all DEPTH entries are usable.
module fifo_sync_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       r_en,
   input  logic                       err_clr,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] AF_CNT  = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0] AE_CNT  = PTR_W'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]      w_ptr_q, w_ptr_d;
   logic [PTR_W-1:0]      r_ptr_q, r_ptr_d;
   logic [PTR_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  wr_ok;
   logic                  rd_ok;
   logic [ADDR_W-1:0]     w_addr;
   logic [ADDR_W-1:0]     r_addr;

   assign w_addr = w_ptr_q[ADDR_W-1:0];
   assign r_addr = r_ptr_q[ADDR_W-1:0];

   // Full/empty come only from registered pointers; a same-cycle read never frees a slot.
   assign full  = (w_addr == r_addr) && (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);
   assign empty = (w_ptr_q == r_ptr_q);

   assign wr_ok = w_en & ~full;
   assign rd_ok = r_en & ~empty;

   assign count        = count_q;
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // FWFT shows the head word directly and forces zero while nothing is stored.
   assign data_out = (FWFT != 0) ? (empty ? '0 : mem_q[r_addr]) : data_out_q;

   always_comb begin
      w_ptr_d     = w_ptr_q;
      r_ptr_d     = r_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_ok) begin
         w_ptr_d = w_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         r_ptr_d = r_ptr_q + PTR_ONE;
         if (FWFT == 0) begin
            data_out_d = mem_q[r_addr];
         end
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase

      // A new error in the same cycle as err_clr keeps the flag set.
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (w_en & full) begin
         overflow_d = 1'b1;
      end
      if (r_en & empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[w_addr] <= data_in;
      end
   end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - directed self-checking bench for fifo_sync_flags
// Instance u_reg uses registered reads, u_fwft uses first-word-fall-through.
module tb_fifo_sync_flags;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   logic       w_en1 = 1'b0, r_en1 = 1'b0, err_clr1 = 1'b0;
   logic [7:0] data_in1 = 8'h00;
   logic [7:0] data_out1;
   logic       full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
   logic [3:0] count1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .err_clr(err_clr),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .w_en(w_en1), .data_in(data_in1), .r_en(r_en1), .err_clr(err_clr1),
      .data_out(data_out1), .full(full1), .empty(empty1), .almost_full(almost_full1),
      .almost_empty(almost_empty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
   );

   task automatic test_reset();
      @(negedge clk);
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", data_out); end
      checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
      checks++; if (data_out1 !== 8'h00 || empty1 !== 1'b1) begin failures++; $display("FAIL reset_fwft got=%h/%b exp=00/1", data_out1, empty1); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         w_en = 1'b1; data_in = 8'(i);
         @(negedge clk);
         checks++; if (count !== 4'(i)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
         checks++; if (almost_full !== (i >= 6)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 6)); end
         checks++; if (full !== (i == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 8)); end
      end
      w_en = 1'b0;
   endtask

   task automatic test_overflow();
      w_en = 1'b1; data_in = 8'hAA;
      @(negedge clk);
      w_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
      @(negedge clk);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 8; i++) begin
         r_en = 1'b1;
         @(negedge clk);
         checks++; if (data_out !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, 8'(i)); end
         checks++; if (count !== 4'(8 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 8 - i); end
         checks++; if (almost_empty !== ((8 - i) <= 2)) begin failures++; $display("FAIL drain_ae[%0d] got=%b exp=%b", i, almost_empty, ((8 - i) <= 2)); end
         checks++; if (empty !== (i == 8)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == 8)); end
      end
      r_en = 1'b0;
   endtask

   task automatic test_underflow();
      r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b exp=1", underflow); end
      checks++; if (data_out !== 8'h08) begin failures++; $display("FAIL udf_dout got=%h exp=08", data_out); end
      checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL udf_state got=%0d/%b exp=0/1", count, empty); end
   endtask

   task automatic test_err_clr();
      // Clear coinciding with a fresh underflow: underflow stays, overflow clears.
      err_clr = 1'b1; r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b01) begin failures++; $display("FAIL clr_collide got=%b exp=01", {overflow, underflow}); end
      @(negedge clk);
      err_clr = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL clr_flags got=%b exp=00", {overflow, underflow}); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) begin
         w_en = 1'b1; data_in = 8'h10 + 8'(i);
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         w_en = 1'b1; r_en = 1'b1; data_in = 8'h14 + 8'(i);
         @(negedge clk);
         checks++; if (count !== 4'd4) begin failures++; $display("FAIL sim_count[%0d] got=%0d exp=4", i, count); end
         checks++; if (data_out !== 8'h10 + 8'(i)) begin failures++; $display("FAIL sim_data[%0d] got=%h exp=%h", i, data_out, 8'h10 + 8'(i)); end
      end
      w_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         r_en = 1'b1;
         @(negedge clk);
         checks++; if (data_out !== 8'h15 + 8'(i)) begin failures++; $display("FAIL sim_tail[%0d] got=%h exp=%h", i, data_out, 8'h15 + 8'(i)); end
      end
      r_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w_en = 1'b1; data_in = 8'h20 + 8'(i);
         @(negedge clk);
      end
      w_en = 1'b1; r_en = 1'b1; data_in = 8'hBB;
      @(negedge clk);
      w_en = 1'b0; r_en = 1'b0;
      checks++; if (count !== 4'd7) begin failures++; $display("FAIL simfull_count got=%0d exp=7", count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL simfull_ovf got=%b exp=1", overflow); end
      checks++; if (data_out !== 8'h20) begin failures++; $display("FAIL simfull_data got=%h exp=20", data_out); end
      for (int i = 1; i < 8; i++) begin
         r_en = 1'b1;
         @(negedge clk);
         checks++; if (data_out !== 8'h20 + 8'(i)) begin failures++; $display("FAIL simfull_tail[%0d] got=%h exp=%h", i, data_out, 8'h20 + 8'(i)); end
      end
      r_en = 1'b0;
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simfull_empty got=%b exp=1", empty); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] wv;
      logic [7:0] ev;
      wv = 8'h40; ev = 8'h40;
      for (int c = 0; c < 20; c++) begin
         w_en = (c < 19); r_en = (c > 0); data_in = wv;
         @(negedge clk);
         if (w_en) wv = wv + 8'h01;
         if (r_en) begin
            checks++; if (data_out !== ev) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", c, data_out, ev); end
            ev = ev + 8'h01;
         end
         if (c < 19) begin
            checks++; if (count !== 4'd1 || full !== 1'b0 || empty !== 1'b0) begin
               failures++; $display("FAIL wrap_state[%0d] got=%0d/%b/%b exp=1/0/0", c, count, full, empty);
            end
         end
      end
      w_en = 1'b0; r_en = 1'b0;
      checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=1/0", empty, count); end
   endtask

   task automatic test_fwft();
      w_en1 = 1'b1; data_in1 = 8'h5A;
      @(negedge clk);
      w_en1 = 1'b0;
      checks++; if (empty1 !== 1'b0 || data_out1 !== 8'h5A) begin failures++; $display("FAIL fwft_show got=%b/%h exp=0/5a", empty1, data_out1); end
      @(negedge clk);
      checks++; if (data_out1 !== 8'h5A) begin failures++; $display("FAIL fwft_hold got=%h exp=5a", data_out1); end
      r_en1 = 1'b1;
      @(negedge clk);
      r_en1 = 1'b0;
      checks++; if (empty1 !== 1'b1 || data_out1 !== 8'h00) begin failures++; $display("FAIL fwft_pop got=%b/%h exp=1/00", empty1, data_out1); end
      for (int i = 0; i < 2; i++) begin
         w_en1 = 1'b1; data_in1 = (i == 0) ? 8'h11 : 8'h22;
         @(negedge clk);
      end
      w_en1 = 1'b0;
      checks++; if (data_out1 !== 8'h11) begin failures++; $display("FAIL fwft_head got=%h exp=11", data_out1); end
      r_en1 = 1'b1;
      @(negedge clk);
      checks++; if (data_out1 !== 8'h22) begin failures++; $display("FAIL fwft_next got=%h exp=22", data_out1); end
      @(negedge clk);
      r_en1 = 1'b0;
      checks++; if (empty1 !== 1'b1 || count1 !== 4'd0) begin failures++; $display("FAIL fwft_drained got=%b/%0d exp=1/0", empty1, count1); end
   endtask

   task automatic test_async_reset();
      r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w_en = 1'b1; data_in = 8'h60 + 8'(i);
         @(negedge clk);
      end
      w_en = 1'b0; r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      checks++; if (count !== 4'd5 || data_out !== 8'h60 || underflow !== 1'b1) begin
         failures++; $display("FAIL arst_pre got=%0d/%h/%b exp=5/60/1", count, data_out, underflow);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL arst_empty got=%b/%b exp=1/0", empty, full); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL arst_dout got=%h exp=00", data_out); end
      checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL arst_flags got=%b exp=00", {overflow, underflow}); end
      @(negedge clk);
      rst = 1'b0;
      w_en = 1'b1; data_in = 8'h33;
      @(negedge clk);
      w_en = 1'b0; r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      checks++; if (data_out !== 8'h33) begin failures++; $display("FAIL arst_after got=%h exp=33", data_out); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_after_empty got=%b exp=1", empty); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_underflow();
      test_err_clr();
      test_simultaneous();
      test_wrap();
      test_fwft();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous single-clock FIFO. Next generation of the team's basic FIFO.
- Uses full-depth storage: all DEPTH entries are usable, tracked with an extra pointer wrap bit.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the standard buffering element between producer/consumer stages in the datapath.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- r_en  input  1  read request (in FWFT mode: pop/acknowledge).
- err_clr  input  1  synchronous clear of the sticky error flags.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, sync release):
  - w_ptr, r_ptr, count = 0; data_out = 0; overflow = underflow = 0.
  - full = 0; empty = 1; almost_empty = 1; almost_full = 0 (given AF_LEVEL > 0).
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits, where ADDR_W = $clog2(DEPTH). The low ADDR_W bits address memory; the MSB is the wrap bit.
  - full when the address bits are equal and the wrap bits differ.
  - empty when the pointers are equal.
- Write accept: wr_ok = w_en & !full. On wr_ok: mem[w_ptr] <= data_in; w_ptr increments, wrapping naturally.
- Read accept: rd_ok = r_en & !empty. On rd_ok: r_ptr increments.
- Full/empty decisions use registered state only. A simultaneous read does NOT free space for a write in the same cycle:
  - w_en while full is rejected, even if r_en is also high.
  - r_en while empty is rejected, even if w_en is also high.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. All flags are derived from registered count/pointers, so they change on the edge after the accepted operation.
- FWFT = 0 (registered read):
  - On rd_ok, data_out <= mem[r_ptr], valid the cycle after r_en is sampled.
  - data_out holds its value when there is no rd_ok.
  - Read latency is 1 clock.
- FWFT = 1 (first-word-fall-through):
  - data_out = mem[r_ptr[ADDR_W-1:0]] when !empty; 0 when empty.
  - A word written at edge k is visible on data_out, with empty low, after edge k.
  - r_en consumes the currently shown word; the next word appears after that edge.
- Overflow/underflow flags:
  - overflow <= 1 on (w_en & full).
  - underflow <= 1 on (r_en & empty).
  - Both stay set until err_clr or rst.
  - If err_clr coincides with a new error event, the flag is set: the error wins.
  - Rejected operations change no pointer, count or data.
- Wrap-around: the pointers wrap through 0 with no discontinuity. full/empty stay correct across any number of wraps.
- Reset asserted mid-stream: outputs take their reset values immediately (asynchronously). Data in flight is discarded.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Fill/drain, FWFT=0: write 0x01..0x08 on 8 consecutive cycles.
  - Required: full=1 and count=8 after the 8th edge; almost_full rises after the 6th write.
  - Then read 8 cycles: data_out = 0x01..0x08, each one cycle after its r_en; empty=1 after the last read; almost_empty=1 once count<=2.
- Overflow/underflow:
  - With the FIFO full, write 0xAA: overflow=1, count stays 8, and 0xAA is never read out.
  - After draining, pulse r_en: underflow=1, data_out unchanged.
  - Pulse err_clr: both flags return to 0.
- Simultaneous read/write:
  - At count=4, assert w_en and r_en for 5 cycles: count stays 4 and read order is preserved.
  - At full with both asserted: the read is accepted, the write is rejected, overflow=1, count=7.
- Wrap-around: 20 cycles of interleaved writes and reads with an incrementing pattern.
  - Every read matches the expected sequence; the pointers wrap at least twice; full/empty are never falsely asserted.
- FWFT=1: write 0x5A at edge k.
  - After edge k: empty=0 and data_out=0x5A with no r_en.
  - Pulse r_en: data_out=0 and empty=1 after the next edge.
- Async reset mid-operation: with count=5, assert rst between clock edges.
  - Immediately: count=0, empty=1, data_out=0, flags cleared.
  - After release, writing 0x33 and reading it returns 0x33.
